// File: rtl/keccak_pkg.sv
// Shared constants, types and the lane-to-bit mapping for the Keccak theta stage.
package keccak_pkg;

    localparam int SW = 25;
    localparam int W  = 64;

    typedef logic [0:SW-1] slice_t;

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    // Lane (x,y) sits at bit 5*((y+2)%5) + (x+2)%5 of a slice, so lane (0,0) is bit 12.
    function automatic int lane_idx(input int x, input int y);
        return 5 * ((y + 2) % 5) + (x + 2) % 5;
    endfunction

endpackage

// File: rtl/keccak_theta_colpar.sv
// Combinational column parities of one 25-bit Keccak slice.
module keccak_theta_colpar
    import keccak_pkg::*;
(
    input  slice_t     slice,
    output logic [4:0] parity
);

    logic [4:0][4:0] col_bits;

    for (genvar x = 0; x < 5; x++) begin : g_col
        for (genvar y = 0; y < 5; y++) begin : g_row
            localparam int P = lane_idx(x, y);
            assign col_bits[x][y] = slice[P];
        end
        assign parity[x] = ^col_bits[x];
    end

endmodule

// File: rtl/keccak_theta_stage.sv
// Keccak-f[1600] theta step: serial slice load with running column parities,
// one registered compute cycle, parallel slice-array result held until acknowledged.
module keccak_theta_stage
    import keccak_pkg::*;
#(
    parameter int W = keccak_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  slice_t         in_slice,
    output logic           out_valid,
    input  logic           out_ready,
    output slice_t [0:W-1] out_mem,
    output logic           busy
);

    localparam int CW = $clog2(W);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    slice_t [0:W-1]       buffer;
    logic [0:W-1][4:0]    par_store;
    logic [4:0]           slice_par;
    slice_t [0:W-1]       theta_next;

    keccak_theta_colpar u_colpar (
        .slice  (in_slice),
        .parity (slice_par)
    );

    // Slice z mixes in its own column x-1 parity and the previous slice's column x+1
    // parity; slice 0 wraps to slice W-1.
    for (genvar z = 0; z < W; z++) begin : g_slice
        localparam int ZP = (z + W - 1) % W;
        for (genvar x = 0; x < 5; x++) begin : g_col
            for (genvar y = 0; y < 5; y++) begin : g_row
                localparam int P = lane_idx(x, y);
                assign theta_next[z][P] = buffer[z][P]
                                        ^ par_store[z][(x + 4) % 5]
                                        ^ par_store[ZP][(x + 1) % 5];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (in_valid && count == CW'(W - 1)) state_next = CALC;
            CALC:    state_next = OUT;
            OUT:     if (out_ready) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state == LOAD && count != '0) || (state == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            buffer    <= '0;
            par_store <= '0;
            out_mem   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        buffer[count]    <= in_slice;
                        par_store[count] <= slice_par;
                        count            <= count + 1'b1;
                    end
                end
                CALC: begin
                    out_mem   <= theta_next;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_theta_stage.sv
// Scoreboard bench for keccak_theta_stage: directed vectors plus a golden theta model.
module tb_keccak_theta_stage;

    typedef logic [0:63][0:24] mem_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [0:24] in_slice;
    logic       out_valid;
    logic       out_ready;
    mem_t       out_mem;
    logic       busy;

    int errors = 0;
    int checks = 0;

    mem_t  exp_q[$];
    string name_q[$];

    keccak_theta_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mem   (out_mem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int pos(input int x, input int y);
        return 5 * ((y + 2) % 5) + (x + 2) % 5;
    endfunction

    // Textbook theta in lane form: D[x][z] = C[x-1][z] ^ C[x+1][z-1].
    function automatic mem_t theta_model(input mem_t a);
        bit   c [5][64];
        mem_t r;
        for (int x = 0; x < 5; x++)
            for (int z = 0; z < 64; z++) begin
                c[x][z] = 1'b0;
                for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ a[z][pos(x, y)];
            end
        r = a;
        for (int z = 0; z < 64; z++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    r[z][pos(x, y)] = r[z][pos(x, y)] ^ c[(x + 4) % 5][z] ^ c[(x + 1) % 5][(z + 63) % 64];
        return r;
    endfunction

    function automatic mem_t random_state();
        mem_t r;
        for (int z = 0; z < 64; z++) r[z] = 25'($urandom);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic compare_mem(input string name, input mem_t actual, input mem_t expected);
        int first_z;
        checks++;
        if (actual !== expected) begin
            errors++;
            first_z = 0;
            for (int z = 63; z >= 0; z--) if (actual[z] !== expected[z]) first_z = z;
            $display("[TB] FAIL %s: slice %0d got %07h, expected %07h", name, first_z,
                     actual[first_z], expected[first_z]);
        end
    endtask

    // Called just after a rising edge while the DUT is in LOAD.
    task automatic apply_stimulus(input string name, input mem_t s, input mem_t expected,
                                  input bit gaps, input bit push);
        if (push) begin
            exp_q.push_back(expected);
            name_q.push_back(name);
        end
        for (int z = 0; z < 64; z++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_slice = s[z];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(name, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(name, 32'(out_valid), 32'd1);
    endtask

    // Monitor: every accepted output is checked against the oldest expected result.
    always @(negedge clk) begin
        mem_t  e;
        string n;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got out_valid=1, expected no pending result");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                compare_mem(n, out_mem, e);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem_t v, e, r;
        int   hi_cols [5] = '{3, 8, 13, 18, 23};
        int   lo_cols [5] = '{1, 6, 11, 16, 21};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_slice  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        compare_mem("reset_out_mem", out_mem, '0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // All-zero state, with cycle-exact latency checks around the compute step.
        out_ready = 1'b1;
        v = '0;
        apply_stimulus("all_zero", v, v, 1'b0, 1'b1);
        check_output("calc_in_ready", 32'(in_ready), 32'd0);
        check_output("calc_busy", 32'(busy), 32'd1);
        check_output("calc_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_output("out_valid_rise", 32'(out_valid), 32'd1);
        check_output("out_busy", 32'(busy), 32'd0);
        check_output("out_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_output("return_in_ready", 32'(in_ready), 32'd1);
        check_output("return_out_valid", 32'(out_valid), 32'd0);

        // Single bit at lane (0,0) of slice 0.
        v = '0; v[0][12] = 1'b1;
        e = '0; e[0][12] = 1'b1;
        foreach (hi_cols[i]) e[0][hi_cols[i]] = 1'b1;
        foreach (lo_cols[i]) e[1][lo_cols[i]] = 1'b1;
        apply_stimulus("single_bit_z0", v, e, 1'b0, 1'b1);
        wait_load("single_bit_z0_done");

        // Single bit in slice 63: the z-1 term wraps into slice 0.
        v = '0; v[63][12] = 1'b1;
        e = '0; e[63][12] = 1'b1;
        foreach (hi_cols[i]) e[63][hi_cols[i]] = 1'b1;
        foreach (lo_cols[i]) e[0][lo_cols[i]] = 1'b1;
        apply_stimulus("wrap_z63", v, e, 1'b0, 1'b1);
        wait_load("wrap_z63_done");

        // Two bits in one column cancel: output equals input.
        v = '0; v[5][12] = 1'b1; v[5][17] = 1'b1;
        apply_stimulus("even_parity", v, v, 1'b0, 1'b1);
        wait_load("even_parity_done");

        // Backpressure: result held, slices offered meanwhile are ignored.
        out_ready = 1'b0;
        r = random_state();
        e = theta_model(r);
        apply_stimulus("backpressure", r, e, 1'b0, 1'b1);
        wait_out_valid("bp_out_valid_rise");
        in_valid = 1'b1;
        in_slice = 25'h1ffffff;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_output("bp_out_valid", 32'(out_valid), 32'd1);
            check_output("bp_in_ready", 32'(in_ready), 32'd0);
            compare_mem("bp_out_mem", out_mem, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("bp_release_in_ready", 32'(in_ready), 32'd1);
        check_output("bp_release_out_valid", 32'(out_valid), 32'd0);
        compare_mem("bp_out_mem_kept", out_mem, e);

        // Reset after 30 slices discards the partial load.
        out_ready = 1'b1;
        for (int z = 0; z < 30; z++) begin
            in_valid = 1'b1;
            in_slice = 25'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_output("midload_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("midload_rst_busy", 32'(busy), 32'd0);
        check_output("midload_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        r = random_state();
        apply_stimulus("reset_reload", r, theta_model(r), 1'b1, 1'b1);
        wait_load("reset_reload_done");

        // Another random vector with gaps, out_ready held high.
        r = random_state();
        apply_stimulus("random_gaps", r, theta_model(r), 1'b1, 1'b1);
        wait_load("random_gaps_done");

        // Reset while a result is waiting drops out_valid without a clock edge.
        out_ready = 1'b0;
        r = random_state();
        apply_stimulus("reset_in_out", r, theta_model(r), 1'b0, 1'b0);
        wait_out_valid("rst_out_valid_rise");
        #2 rst = 1'b1;
        #1;
        check_output("rst_in_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_out_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
